sync_fifo_ext: RTL and testbench

Parametrised next-generation synchronous FIFO: single clock, power-of-two depth, registered (standard) or first-word-fall-through (FWFT) read mode. Adds occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags clearable by the producer/consumer. Drop-in buffer between datapath stages wherever the existing basic FIFO lacks flow-control headroom or error visibility.

---
 rtl/sync_fifo_ext.sv | 103 ++++++++++
 tb/tb_sync_fifo_ext.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and optional first-word-fall-through.
module sync_fifo_ext #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned FWFT          = 0,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_inc_c;
    logic [AW-1:0]    head_ptr_c;
    logic [WIDTH-1:0] head_next_c;
    logic             wr_acc_c;
    logic             rd_acc_c;
    logic [CW-1:0]    count_next_c;

    // Accept decisions; a full FIFO still takes a write when a read frees a slot.
    // The next head word bypasses storage when it is being written this cycle.
    always_comb begin
        rd_acc_c     = rd_en && !empty;
        wr_acc_c     = wr_en && (!full || rd_acc_c);
        count_next_c = count + CW'(wr_acc_c) - CW'(rd_acc_c);
        rd_ptr_inc_c = rd_ptr + AW'(1);
        head_ptr_c   = rd_acc_c ? rd_ptr_inc_c : rd_ptr;
        head_next_c  = (wr_acc_c && (wr_ptr == head_ptr_c)) ? din : mem[head_ptr_c];
    end

    // Storage array is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr_inc_c;
            end
            count        <= count_next_c;
            full         <= (count_next_c == CW'(DEPTH));
            empty        <= (count_next_c == '0);
            almost_full  <= (count_next_c >= CW'(AFULL_THRESH));
            almost_empty <= (count_next_c <= CW'(AEMPTY_THRESH));

            // FWFT keeps the head word registered on dout; an empty FIFO holds the last head.
            if (FWFT != 0) begin
                if (count_next_c != '0) begin
                    dout <= head_next_c;
                end
                dout_valid <= (count_next_c != '0);
            end else begin
                if (rd_acc_c) begin
                    dout <= mem[rd_ptr];
                end
                dout_valid <= rd_acc_c;
            end

            // Set takes priority over clear.
            overflow  <= (overflow  && !clr_err) || (wr_en && !wr_acc_c);
            underflow <= (underflow && !clr_err) || (rd_en && !rd_acc_c);
        end
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: standard and FWFT instances share stimulus and are
// checked against a queue-based reference model and a read-data scoreboard.
module tb_sync_fifo_ext;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFT   = DEPTH - 2;
    localparam int unsigned AET   = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] din = '0;

    logic [WIDTH-1:0] s_dout, f_dout;
    logic             s_dv, f_dv;
    logic             s_full, f_full, s_empty, f_empty;
    logic             s_af, f_af, s_ae, f_ae;
    logic [CW-1:0]    s_cnt, f_cnt;
    logic             s_ovf, f_ovf, s_udf, f_udf;

    sync_fifo_ext #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err));

    sync_fifo_ext #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err));

    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] sb_q[$];
    bit               m_ovf = 1'b0;
    bit               m_udf = 1'b0;
    bit               m_dv  = 1'b0;
    bit               mon_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        sb_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_dv  = 1'b0;
    endtask

    // Drive one cycle of stimulus and advance the model to the post-edge state.
    task automatic op(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
        int  occ;
        bit  wa, ra;
        @(negedge clk);
        #1;
        occ = model_q.size();
        ra  = r && (occ > 0);
        wa  = w && ((occ < int'(DEPTH)) || ra);
        m_dv = ra;
        if (ra) sb_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        m_ovf = (m_ovf && !c) || (w && !wa);
        m_udf = (m_udf && !c) || (r && !ra);
        wr_en   = w;
        din     = d;
        rd_en   = r;
        clr_err = c;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr_err = 1'b0;
        model_reset();
        #1;
        chk("rst_dout_std", 32'(s_dout), 32'h0);
        chk("rst_dout_fwft", 32'(f_dout), 32'h0);
        chk("rst_dv_std", 32'(s_dv), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: flags against model, read data against scoreboard.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            int occ;
            occ = model_q.size();
            chk("count_std",  32'(s_cnt), 32'(occ));
            chk("count_fwft", 32'(f_cnt), 32'(occ));
            chk("full_std",   32'(s_full),  32'(occ == int'(DEPTH)));
            chk("full_fwft",  32'(f_full),  32'(occ == int'(DEPTH)));
            chk("empty_std",  32'(s_empty), 32'(occ == 0));
            chk("empty_fwft", 32'(f_empty), 32'(occ == 0));
            chk("afull_std",  32'(s_af), 32'(occ >= int'(AFT)));
            chk("afull_fwft", 32'(f_af), 32'(occ >= int'(AFT)));
            chk("aempty_std", 32'(s_ae), 32'(occ <= int'(AET)));
            chk("aempty_fwft",32'(f_ae), 32'(occ <= int'(AET)));
            chk("ovf_std",  32'(s_ovf), 32'(m_ovf));
            chk("ovf_fwft", 32'(f_ovf), 32'(m_ovf));
            chk("udf_std",  32'(s_udf), 32'(m_udf));
            chk("udf_fwft", 32'(f_udf), 32'(m_udf));
            chk("dv_std",   32'(s_dv),  32'(m_dv));
            if (s_dv) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underrun", 32'(s_dout), 32'hDEAD);
                end else begin
                    chk("rdata_std", 32'(s_dout), 32'(sb_q.pop_front()));
                end
            end
            chk("dv_fwft", 32'(f_dv), 32'(occ != 0));
            if (occ != 0) chk("head_fwft", 32'(f_dout), 32'(model_q[0]));
        end
    end

    initial begin
        int phase_w, phase_r;

        // Reset state
        repeat (2) @(negedge clk);
        chk("init_dout", 32'(s_dout), 32'h0);
        chk("init_empty", 32'(s_empty), 32'h1);
        chk("init_ae", 32'(s_ae), 32'h1);
        chk("init_count", 32'(s_cnt), 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Three writes then three reads
        op(1, 8'hAA, 0, 0);
        op(1, 8'hBB, 0, 0);
        op(1, 8'hCC, 0, 0);
        repeat (3) op(0, 8'h00, 1, 0);
        repeat (2) op(0, 8'h00, 0, 0);

        // Fill, overflow attempt, simultaneous at full, drain, clear
        for (int i = 0; i < int'(DEPTH); i++) op(1, 8'(i), 0, 0);
        op(1, 8'hFF, 0, 0);
        op(1, 8'h55, 1, 0);
        repeat (DEPTH + 1) op(0, 8'h00, 1, 0);
        op(0, 8'h00, 0, 1);

        // Simultaneous at empty, then retrieve, clear
        op(1, 8'h66, 1, 0);
        op(0, 8'h00, 1, 0);
        op(0, 8'h00, 0, 1);
        op(0, 8'h00, 0, 0);

        // Interleaved wrap-around
        for (int i = 0; i < 20; i++) op(1, 8'(i), i >= 3, 0);
        repeat (5) op(0, 8'h00, 1, 0);

        // Clear coinciding with new error: set wins
        op(0, 8'h00, 1, 1);
        op(0, 8'h00, 0, 1);

        // Reset during activity
        for (int i = 0; i < 5; i++) op(1, 8'(8'h30 + i), i == 4, 0);
        do_reset();
        op(1, 8'h3C, 0, 0);
        op(0, 8'h00, 0, 0);
        op(0, 8'h00, 1, 0);
        op(0, 8'h00, 1, 0);

        // Randomized phases with varying write/read bias
        for (int p = 0; p < 12; p++) begin
            phase_w = $urandom_range(10, 90);
            phase_r = $urandom_range(10, 90);
            for (int i = 0; i < 120; i++) begin
                op($urandom_range(0, 99) < phase_w, 8'($urandom),
                   $urandom_range(0, 99) < phase_r, $urandom_range(0, 99) < 5);
            end
        end
        repeat (DEPTH + 2) op(0, 8'h00, 1, 0);
        repeat (2) op(0, 8'h00, 0, 0);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
